// File: rtl/fc_pkg.sv
// ----------------------------------------------------------------------------
// fc_pkg
// Shared types and constants for the gated frequency counter.
//   fc_state_t  : FSM states (IDLE, ARM, COUNT)
//   FC_CNT_W    : result width, matches the downstream binary-to-BCD converter
//   FC_CNT_MAX  : saturation value of the edge counter
// ----------------------------------------------------------------------------
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } fc_state_t;

    localparam int                  FC_CNT_W   = 12;
    localparam logic [FC_CNT_W-1:0] FC_CNT_MAX = 12'hFFF;

endpackage

// File: rtl/fc_edge_sync.sv
// ----------------------------------------------------------------------------
// fc_edge_sync
// Brings the asynchronous measured signal into the clk domain and produces a
// one-cycle pulse for each synchronized rising edge.
//   sig -> SYNC_STAGES flops -> [optional deglitch flop] -> history flop
//   edge = level & ~history
// Optional feature macro: FC_DEGLITCH_EN (adds a filter stage that changes
// level only after two equal consecutive samples; one extra cycle of latency).
//
// Parameters
//   SYNC_STAGES  synchronizer depth, must be >= 2
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous reset, active low
//   i_sig    in   measured signal, asynchronous to clk
//   o_edge   out  one-cycle pulse per synchronized rising edge
// ----------------------------------------------------------------------------
module fc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_level;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its neighbour, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
        end
    end

`ifdef FC_DEGLITCH_EN
    logic r_filt;

    // r_sync[SYNC_STAGES-2] is the value r_sync[SYNC_STAGES-1] takes next
    // cycle, so comparing the two compares two consecutive samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
        end else if (r_sync[SYNC_STAGES-1] == r_sync[SYNC_STAGES-2]) begin
            r_filt <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    // History tracks the level every cycle, so a level that is already high
    // when a window is armed never looks like a new edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= w_level;
        end
    end

    assign o_edge = w_level & ~r_hist;

endmodule

// File: rtl/freq_gate_counter.sv
// ----------------------------------------------------------------------------
// freq_gate_counter
// Counts synchronized rising edges of sig_in over back-to-back windows of
// GATE_CYCLES clk cycles and publishes the saturated count on freq with a
// one-cycle freq_valid strobe. freq drives the binary-to-BCD converter.
// Optional feature macro: FC_DEGLITCH_EN (see fc_edge_sync).
//
// Parameters
//   GATE_CYCLES  clk cycles per window, must be >= 4
//   CNT_W        width of edge counter and freq
//   SYNC_STAGES  synchronizer depth, must be >= 2
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous reset, active low
//   sig_in      in   measured signal, asynchronous to clk
//   enable      in   1 = measure continuously, 0 = abort and idle
//   freq        out  edge count of last completed window (saturated)
//   freq_valid  out  one-cycle pulse when freq updates
//   overflow    out  last completed window saturated
// ----------------------------------------------------------------------------
module freq_gate_counter
    import fc_pkg::*;
#(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = FC_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    fc_state_t         r_state;
    fc_state_t         w_state_nxt;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_sat;
    logic [CNT_W-1:0]  r_freq;
    logic              r_freq_valid;
    logic              r_overflow;

    logic              w_edge;
    logic              w_counting;
    logic              w_window_end;
    logic [CNT_W-1:0]  w_edge_cnt_nxt;
    logic              w_sat_nxt;

    fc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (sig_in),
        .o_edge (w_edge)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (enable) w_state_nxt = ARM;
            ARM:     w_state_nxt = COUNT;
            COUNT:   if (!enable) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- Edge accumulation ----------------
    // Window end is only honoured while enable is high: a simultaneous
    // disable discards the window instead of publishing it.
    always_comb begin
        w_counting     = (r_state == COUNT) && enable;
        w_window_end   = w_counting && (r_gate_cnt == GATE_LAST);
        w_edge_cnt_nxt = r_edge_cnt;
        w_sat_nxt      = r_sat;
        if (w_edge) begin
            if (r_edge_cnt == CNT_MAX) begin
                w_sat_nxt = 1'b1;
            end else begin
                w_edge_cnt_nxt = r_edge_cnt + CNT_W'(1);
            end
        end
    end

    // The last cycle's edge is folded in via w_edge_cnt_nxt while the
    // counters restart, so the next window begins with no dead cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_sat        <= 1'b0;
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_freq_valid <= 1'b0;
            if (r_state == ARM) begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_sat      <= 1'b0;
            end else if (w_window_end) begin
                r_gate_cnt   <= '0;
                r_edge_cnt   <= '0;
                r_sat        <= 1'b0;
                r_freq       <= w_edge_cnt_nxt;
                r_overflow   <= w_sat_nxt;
                r_freq_valid <= 1'b1;
            end else if (w_counting) begin
                r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                r_edge_cnt <= w_edge_cnt_nxt;
                r_sat      <= w_sat_nxt;
            end
        end
    end

    assign freq       = r_freq;
    assign freq_valid = r_freq_valid;
    assign overflow   = r_overflow;

endmodule
